// File: rtl/icache_param.sv
// Parametrised read-only instruction cache (LINES sets x WAYS ways x WORDS words).
// Optional critical-word early restart: define ICACHE_EARLY_RESP_EN.
module icache_param #(
    parameter int LINES = 4,
    parameter int WORDS = 4,
    parameter int WAYS  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    input  logic        flush,
    output logic        axi_start,
    output logic [31:0] axi_addr,
    output logic [7:0]  axi_len,
    input  logic [31:0] axi_rdata,
    input  logic        axi_rvalid,
    input  logic        axi_done,
    input  logic        axi_busy,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int WRD_W  = $clog2(WORDS);
    localparam int OFF_W  = WRD_W + 2;
    localparam int IDX_W  = $clog2(LINES);
    localparam int LINE_W = 32 - OFF_W;
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam int CNT_W  = WRD_W + 1;

    generate
        if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
            $error("icache_param: WAYS must be 1 or 2");
        end
    endgenerate

    typedef enum logic {IDLE, REFILL} state_t;
    state_t state_q, state_d;

    logic [31:0]      data_q [WAYS][LINES][WORDS];
    logic [TAG_W-1:0] tags_q [WAYS][LINES];

    logic [LINES-1:0][WAYS-1:0] valid_q;
    logic [LINES-1:0]           lru_q;

    logic              resp_valid_q;
    logic [31:0]       resp_inst_q;
    logic              axi_start_q;
    logic [31:0]       axi_addr_q;
    logic [31:0]       hit_cnt_q;
    logic [31:0]       miss_cnt_q;
    logic              flush_pend_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              started_q;
    logic [LINE_W-1:0] line_q;
    logic [WRD_W-1:0]  wsel_q;
    logic              victim_q;
    logic [31:0]       crit_q;
`ifdef ICACHE_EARLY_RESP_EN
    logic              early_q;
`endif

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [WRD_W-1:0] req_word;
    logic             unused_addr_bits;

    assign req_idx          = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag          = req_addr[31:OFF_W+IDX_W];
    assign req_word         = req_addr[OFF_W-1:2];
    assign unused_addr_bits = ^req_addr[1:0];

    logic [IDX_W-1:0] idx_r;
    logic [TAG_W-1:0] tag_r;

    assign idx_r = line_q[IDX_W-1:0];
    assign tag_r = line_q[LINE_W-1:IDX_W];

    logic [WAYS-1:0] hit_vec;
    logic            hit_way;
    logic            victim;
    logic            hit;
    logic [31:0]     hit_word;

    // A simultaneous flush forces the lookup to miss and the victim to way 0.
    always_comb begin
        hit_vec = '0;
        hit_way = 1'b0;
        victim  = (WAYS == 2) ? lru_q[req_idx] : 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[req_idx][w] && (tags_q[w][req_idx] == req_tag);
            if (hit_vec[w]) hit_way = 1'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim = 1'(w);
        end
        if (flush) victim = 1'b0;
    end

    assign hit      = (|hit_vec) && !flush;
    assign hit_word = data_q[hit_way][req_idx][req_word];

    logic             refill_st;
    logic             beat_wr;
    logic [WRD_W-1:0] beat_idx;
    logic             crit_beat;
    logic             done_ev;
    logic [CNT_W-1:0] beats_total;
    logic             fill_full;
    logic             commit;

    assign refill_st   = (state_q == REFILL);
    assign beat_wr     = refill_st && started_q && axi_rvalid && (beat_cnt_q < CNT_W'(WORDS));
    assign beat_idx    = beat_cnt_q[WRD_W-1:0];
    assign crit_beat   = beat_wr && (beat_idx == wsel_q);
    assign done_ev     = refill_st && started_q && axi_done;
    assign beats_total = beat_cnt_q + CNT_W'(beat_wr);
    assign fill_full   = (beats_total == CNT_W'(WORDS));
    assign commit      = done_ev && fill_full && !flush_pend_q && !flush;

`ifndef ICACHE_EARLY_RESP_EN
    logic [31:0] crit_word;
    assign crit_word = crit_beat ? axi_rdata : crit_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && !hit) state_d = REFILL;
            REFILL:  if (done_ev) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            axi_start_q  <= 1'b0;
            axi_addr_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            beat_cnt_q   <= '0;
            started_q    <= 1'b0;
            valid_q      <= '0;
            lru_q        <= '0;
            line_q       <= '0;
            wsel_q       <= '0;
            victim_q     <= 1'b0;
            crit_q       <= '0;
`ifdef ICACHE_EARLY_RESP_EN
            early_q      <= 1'b0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            axi_start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                        lru_q   <= '0;
                    end
                    if (req_valid) begin
                        line_q <= req_addr[31:OFF_W];
                        wsel_q <= req_word;
                        if (hit) begin
                            resp_valid_q <= 1'b1;
                            resp_inst_q  <= hit_word;
                            hit_cnt_q    <= hit_cnt_q + 32'd1;
                            if (WAYS == 2) lru_q[req_idx] <= ~hit_way;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                            beat_cnt_q <= '0;
                            started_q  <= 1'b0;
                            victim_q   <= victim;
                            crit_q     <= '0;
                            // The victim's old contents are overwritten beat by beat.
                            valid_q[req_idx][victim] <= 1'b0;
`ifdef ICACHE_EARLY_RESP_EN
                            early_q    <= 1'b0;
`endif
                        end
                    end
                end
                REFILL: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (!started_q && !axi_busy) begin
                        axi_start_q <= 1'b1;
                        axi_addr_q  <= {line_q, {OFF_W{1'b0}}};
                        started_q   <= 1'b1;
                    end
                    if (beat_wr) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (crit_beat) crit_q <= axi_rdata;
`ifdef ICACHE_EARLY_RESP_EN
                        if (crit_beat) begin
                            resp_valid_q <= 1'b1;
                            resp_inst_q  <= axi_rdata;
                            early_q      <= 1'b1;
                        end
`endif
                    end
                    if (done_ev) begin
                        started_q    <= 1'b0;
                        flush_pend_q <= 1'b0;
                        if (flush_pend_q || flush) begin
                            valid_q <= '0;
                            lru_q   <= '0;
                        end else if (fill_full) begin
                            valid_q[idx_r][victim_q] <= 1'b1;
                            if (WAYS == 2) lru_q[idx_r] <= ~victim_q;
                        end
`ifdef ICACHE_EARLY_RESP_EN
                        if (!early_q && !crit_beat) begin
                            resp_valid_q <= 1'b1;
                            resp_inst_q  <= crit_q;
                        end
`else
                        resp_valid_q <= 1'b1;
                        resp_inst_q  <= crit_word;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (beat_wr) data_q[victim_q][idx_r][beat_idx] <= axi_rdata;
        if (commit)  tags_q[victim_q][idx_r] <= tag_r;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_inst  = resp_inst_q;
    assign axi_start  = axi_start_q;
    assign axi_addr   = axi_addr_q;
    assign axi_len    = 8'(WORDS);
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_icache_param.sv
// Bench for icache_param (LINES=4, WORDS=4, WAYS=2) against a recency-list cache model.
// Honours ICACHE_EARLY_RESP_EN when the design is built with it.
module tb_icache_param;
    localparam int LINES = 4;
    localparam int WORDS = 4;
    localparam int WAYS  = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        flush;
    logic        axi_start;
    logic [31:0] axi_addr;
    logic [7:0]  axi_len;
    logic [31:0] axi_rdata;
    logic        axi_rvalid;
    logic        axi_done;
    logic        axi_busy;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_param #(.LINES(LINES), .WORDS(WORDS), .WAYS(WAYS)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_inst(resp_inst),
        .flush(flush), .axi_start(axi_start), .axi_addr(axi_addr), .axi_len(axi_len),
        .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_done(axi_done),
        .axi_busy(axi_busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Model state: per set, resident line numbers ordered most-recent first.
    logic [31:0] m_ln [LINES][2];
    int          m_n  [LINES];
    int          m_hit = 0;
    int          m_miss = 0;
    bit          m_ready = 1'b1;
    int          exp_cyc = -1;
    logic [31:0] exp_val = '0;
    int          n_start = 0;
    logic [31:0] start_addr = '0;
    logic [31:0] last_resp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] ln;
        logic [31:0] w;
        ln = a >> 4;
        w  = (a >> 2) & 32'h3;
        return ((ln - 32'h10) << 16) | ((w + 32'd1) * 32'h11);
    endfunction

    function automatic int m_find(input logic [31:0] a);
        logic [31:0] ln;
        int s;
        ln = a >> 4;
        s  = int'(ln % LINES);
        for (int i = 0; i < m_n[s]; i++)
            if (m_ln[s][i] == ln) return i;
        return -1;
    endfunction

    task automatic m_touch(input logic [31:0] a);
        int s;
        int i;
        logic [31:0] t;
        s = int'((a >> 4) % LINES);
        i = m_find(a);
        if (i == 1) begin
            t = m_ln[s][0]; m_ln[s][0] = m_ln[s][1]; m_ln[s][1] = t;
        end
    endtask

    task automatic m_evict(input logic [31:0] a);
        int s;
        s = int'((a >> 4) % LINES);
        if (m_n[s] == WAYS) m_n[s]--;
    endtask

    task automatic m_insert(input logic [31:0] a);
        int s;
        s = int'((a >> 4) % LINES);
        if (m_n[s] > 0) m_ln[s][1] = m_ln[s][0];
        m_ln[s][0] = a >> 4;
        m_n[s]++;
    endtask

    task automatic m_flush();
        for (int s = 0; s < LINES; s++) m_n[s] = 0;
    endtask

    task automatic m_reset();
        m_flush();
        m_hit = 0; m_miss = 0; m_ready = 1'b1; exp_cyc = -1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison of every observable output against the model.
    initial forever begin
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'(cyc == exp_cyc));
        if (resp_valid && cyc == exp_cyc) chk("resp_inst", resp_inst, exp_val);
        if (resp_valid) last_resp = resp_inst;
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("hit_cnt", hit_cnt, m_hit);
        chk("miss_cnt", miss_cnt, m_miss);
        if (axi_start) begin
            n_start++;
            start_addr = axi_addr;
            chk("axi_len", 32'(axi_len), WORDS);
        end
    end

    // One fetch; on a miss, plays the AXI engine. Called just after a rising edge.
    task automatic access(input logic [31:0] a, input int busy_cyc, input int nbeats,
                          input int flush_at, input bit flush_req);
        bit          hit_m;
        bit          pend;
        int          k;
        int          s0;
        int          w;
        logic [31:0] line;
        line = {a[31:4], 4'h0};
        w    = int'(a[3:2]);
        req_valid = 1'b1; req_addr = a; flush = flush_req;
        if (flush_req) m_flush();
        hit_m = !flush_req && (m_find(a) >= 0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        if (hit_m) begin
            m_hit++; m_touch(a);
            exp_cyc = cyc; exp_val = memword(a);
            return;
        end
        m_miss++; m_ready = 1'b0; m_evict(a);
        s0 = n_start; pend = 1'b0; k = 0;
        axi_busy = (busy_cyc > 0);
        do begin
            @(posedge clk); #1;
            k++;
            if (k >= busy_cyc) axi_busy = 1'b0;
        end while (!axi_start && k < 20);
        chk("start_delay", k, busy_cyc + 1);
        chk("axi_addr", axi_addr, line);
        for (int i = 0; i < nbeats; i++) begin
            axi_rvalid = 1'b1;
            axi_rdata  = memword(line + 32'(4 * i));
            flush      = (i == flush_at);
            if (flush) pend = 1'b1;
            @(posedge clk); #1;
`ifdef ICACHE_EARLY_RESP_EN
            if (i == w) begin exp_cyc = cyc; exp_val = memword(a); end
`endif
        end
        axi_rvalid = 1'b0; flush = 1'b0; axi_done = 1'b1;
        @(posedge clk); #1;
        axi_done = 1'b0; m_ready = 1'b1;
`ifdef ICACHE_EARLY_RESP_EN
        if (w >= nbeats) begin exp_cyc = cyc; exp_val = '0; end
`else
        exp_cyc = cyc;
        exp_val = (w < nbeats) ? memword(a) : 32'h0;
`endif
        if (pend) m_flush();
        else if (nbeats == WORDS) m_insert(a);
        chk("start_once", n_start - s0, 1);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic resync();
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        int s0;
        resetn = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        axi_rdata = '0; axi_rvalid = 1'b0; axi_done = 1'b0; axi_busy = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_inst", resp_inst, 32'h0);
        chk("rst_axi_addr", axi_addr, 32'h0);
        chk("rst_axi_start", 32'(axi_start), 32'h0);
        chk("rst_axi_len", 32'(axi_len), 32'd4);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        resetn = 1'b1;
        resync();

        // Cold miss, then a hit to the same line.
        access(32'h100, 0, 4, -1, 1'b0);
        settle();
        chk("cold_resp", last_resp, 32'h11);
        chk("cold_start_addr", start_addr, 32'h100);
        chk("cold_miss_cnt", miss_cnt, 32'd1);
        resync();
        s0 = n_start;
        access(32'h10C, 0, 4, -1, 1'b0);
        settle();
        chk("hit_resp", last_resp, 32'h44);
        chk("hit_cnt_1", hit_cnt, 32'd1);
        chk("hit_no_start", n_start - s0, 0);
        resync();

        // Two-way LRU: 0x040 is the victim when 0x080 arrives.
        access(32'h000, 0, 4, -1, 1'b0);
        access(32'h040, 0, 4, -1, 1'b0);
        access(32'h000, 0, 4, -1, 1'b0);
        access(32'h080, 0, 4, -1, 1'b0);
        access(32'h000, 0, 4, -1, 1'b0);
        access(32'h040, 0, 4, -1, 1'b0);
        settle();
        chk("lru_hits", hit_cnt, 32'd3);
        chk("lru_misses", miss_cnt, 32'd5);
        resync();

        // Flush during refill, flush with a request, flush while idle.
        access(32'h200, 0, 4, 1, 1'b0);
        access(32'h200, 0, 4, -1, 1'b0);
        access(32'h204, 0, 4, -1, 1'b0);
        access(32'h200, 0, 4, -1, 1'b1);
        flush = 1'b1;
        resync();
        flush = 1'b0;
        m_flush();
        access(32'h200, 0, 4, -1, 1'b0);
        settle();
        chk("flush_misses", miss_cnt, 32'd9);
        resync();

        // Engine busy for 5 cycles, then a short burst.
        access(32'h400, 5, 4, -1, 1'b0);
        access(32'h504, 0, 2, -1, 1'b0);
        access(32'h504, 0, 4, -1, 1'b0);
        access(32'h508, 0, 4, -1, 1'b0);

        // Reset in the middle of a burst, then stray beats.
        req_valid = 1'b1; req_addr = 32'h300;
        resync();
        req_valid = 1'b0; m_miss++; m_ready = 1'b0;
        k = 0;
        do begin resync(); k++; end while (!axi_start && k < 20);
        chk("rst_burst_start", k, 1);
        axi_rvalid = 1'b1; axi_rdata = memword(32'h300);
        resync();
        axi_rdata = memword(32'h304);
        resync();
        axi_rvalid = 1'b0; resetn = 1'b0; m_reset();
        resync();
        resetn = 1'b1;
        axi_rvalid = 1'b1; axi_rdata = 32'hDEAD_BEEF;
        resync();
        axi_rvalid = 1'b0; axi_done = 1'b1;
        resync();
        axi_done = 1'b0;
        resync();
        chk("rst_mid_ready", 32'(req_ready), 32'h1);
        access(32'h300, 0, 4, -1, 1'b0);
        settle();
        chk("rst_then_miss", miss_cnt, 32'd1);
        resync();

        // Mid-line word; response timing depends on the early-restart build.
        access(32'h108, 0, 4, -1, 1'b0);
        settle();
        chk("word2_resp", last_resp, 32'h33);
        resync();
        repeat (3) resync();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
